ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// Pipeline control for a 5-stage in-order core: carries decoded control from ID
// through EX/MEM/WB and resolves load-use stalls, branch flushes and forwarding.
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_ex,
  input  logic [2:0]       id_m,
  input  logic [2:0]       id_wb,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_zero,
  output logic             ex_alu_src_b,
  output logic [3:0]       ex_alu_op,
  output logic             mem_mem_write,
  output logic             wb_reg_write,
  output logic [1:0]       wb_mem_to_reg,
  output logic [4:0]       wb_rd,
  output logic             stall,
  output logic             flush_ifid,
  output logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       branch;
    logic       b_type;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_reg_t;

  // Later stages keep only the fields still consumed downstream.
  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [4:0] rd;
  } mem_reg_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [4:0] rd;
  } wb_reg_t;

  ex_reg_t  ex_q, ex_d;
  mem_reg_t mem_q, mem_d;
  wb_reg_t  wb_q, wb_d;
  logic     load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input mem_reg_t m,
                                         input wb_reg_t w);
    if (m.reg_write && m.rd != 5'd0 && m.rd == rs)      return 2'b10;
    else if (w.reg_write && w.rd != 5'd0 && w.rd == rs) return 2'b01;
    else                                                return 2'b00;
  endfunction

  assign load_use = id_valid && ex_q.reg_write && (ex_q.mem_to_reg == 2'b11) &&
                    (ex_q.rd != 5'd0) && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  assign branch_taken = ex_q.branch && (ex_q.b_type ? ex_zero : ~ex_zero);
  // A taken branch squashes the ID instruction, so its load-use stall is moot.
  assign stall        = load_use && !branch_taken;
  assign flush_ifid   = branch_taken;

  always_comb begin
    ex_d = '0;
    if (id_valid && !branch_taken && !load_use) begin
      ex_d.alu_src_b  = id_ex[4];
      ex_d.alu_op     = id_ex[3:0];
      ex_d.branch     = id_m[2];
      ex_d.b_type     = id_m[1];
      ex_d.mem_write  = id_m[0];
      ex_d.reg_write  = id_wb[2];
      ex_d.mem_to_reg = id_wb[1:0];
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
      ex_d.rd         = id_rd;
    end
  end

  always_comb begin
    mem_d            = '0;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.rd         = ex_q.rd;
    wb_d             = '0;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.rd          = mem_q.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt))      stall_cnt <= stall_cnt + 1'b1;
      if (flush_ifid && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign ex_alu_src_b  = ex_q.alu_src_b;
  assign ex_alu_op     = ex_q.alu_op;
  assign mem_mem_write = mem_q.mem_write;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_rd         = wb_q.rd;
  assign fwd_a         = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign fwd_b         = fwd_sel(ex_q.rs2, mem_q, wb_q);

endmodule
